// File: rtl/serv_sleep_ctrl.sv
// WFI sleep/wake controller: REQ/ack handshake into SLEEP, masked pending wake, restart delay.
// All outputs registered (1 cycle); wakeup pulse WAKE_DLY+2 cycles after a wake in SLEEP; no backpressure.
module serv_sleep_ctrl #(
  parameter int IRQ_W    = 2,
  parameter int WAKE_DLY = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IRQ_W-1:0] i_irq,
  input  logic [IRQ_W-1:0] i_irq_en,
  input  logic [IRQ_W-1:0] i_pend_clr,
  input  logic             i_wfi,
  input  logic             i_cnt_done,
  input  logic             i_sleep_ack,
  output logic             o_sleep_req,
  output logic             o_asleep,
  output logic             o_wakeup_req,
  output logic [IRQ_W-1:0] o_pending
);

  typedef enum logic [1:0] {RUN, REQ, SLEEP, WAKE} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wake;
  logic       wakeup_d;

  // Live sources and already-latched pending bits both count, gated by the mask.
  assign wake = |((i_irq | o_pending) & i_irq_en);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wakeup_d = 1'b0;
    case (state_q)
      RUN: begin
        if (i_wfi && i_cnt_done) begin
          if (wake) wakeup_d = 1'b1;
          else      state_d  = REQ;
        end
      end
      REQ: begin
        if (wake) begin
          state_d  = RUN;
          wakeup_d = 1'b1;
        end else if (i_sleep_ack) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (wake) begin
          state_d = WAKE;
          cnt_d   = 8'(WAKE_DLY);
        end
      end
      WAKE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d  = RUN;
          wakeup_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= RUN;
      cnt_q        <= 8'd0;
      o_sleep_req  <= 1'b0;
      o_asleep     <= 1'b0;
      o_wakeup_req <= 1'b0;
      o_pending    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_sleep_req  <= (state_d == REQ) || (state_d == SLEEP);
      o_asleep     <= (state_d == SLEEP);
      o_wakeup_req <= wakeup_d;
      o_pending    <= i_irq | (o_pending & ~i_pend_clr);
    end
  end

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Directed bench for serv_sleep_ctrl: one instance with WAKE_DLY=4, one with WAKE_DLY=0, shared stimulus.
module tb_serv_sleep_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] i_irq;
  logic [1:0] i_irq_en;
  logic [1:0] i_pend_clr;
  logic       i_wfi;
  logic       i_cnt_done;
  logic       i_sleep_ack;

  logic       sreq, aslp, wup;
  logic [1:0] pend;
  logic       sreq0, aslp0, wup0;
  logic [1:0] pend0;

  int total = 0;
  int bad   = 0;

  serv_sleep_ctrl #(.IRQ_W(2), .WAKE_DLY(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_irq_en(i_irq_en),
    .i_pend_clr(i_pend_clr), .i_wfi(i_wfi), .i_cnt_done(i_cnt_done),
    .i_sleep_ack(i_sleep_ack), .o_sleep_req(sreq), .o_asleep(aslp),
    .o_wakeup_req(wup), .o_pending(pend)
  );

  serv_sleep_ctrl #(.IRQ_W(2), .WAKE_DLY(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_irq_en(i_irq_en),
    .i_pend_clr(i_pend_clr), .i_wfi(i_wfi), .i_cnt_done(i_cnt_done),
    .i_sleep_ack(i_sleep_ack), .o_sleep_req(sreq0), .o_asleep(aslp0),
    .o_wakeup_req(wup0), .o_pending(pend0)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_irq       = 2'b00;
    i_irq_en    = 2'b00;
    i_pend_clr  = 2'b00;
    i_wfi       = 1'b0;
    i_cnt_done  = 1'b0;
    i_sleep_ack = 1'b0;
  endtask

  // Leaves the bench just after an edge with reset released: the next cycle is cycle 0.
  task automatic do_reset();
    clear_inputs();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_irq   = 2'b11;
    i_rst_n = 1'b0;
    step();
    step();
    total++;
    if ({sreq, aslp, wup, pend} !== 5'b0) begin
      bad++;
      $display("FAIL reset dut outputs got %b exp 00000", {sreq, aslp, wup, pend});
    end
    total++;
    if ({sreq0, aslp0, wup0, pend0} !== 5'b0) begin
      bad++;
      $display("FAIL reset dut0 outputs got %b exp 00000", {sreq0, aslp0, wup0, pend0});
    end
    i_rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_basic_sleep();
    logic e_sreq, e_aslp, e_wup;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      i_irq_en    = 2'b10;
      i_wfi       = (c == 10) || (c == 5);
      i_cnt_done  = (c == 10);
      i_sleep_ack = (c == 13);
      i_irq       = (c == 20) ? 2'b10 : 2'b00;
      e_sreq = (c >= 11) && (c <= 20);
      e_aslp = (c >= 14) && (c <= 20);
      e_wup  = (c == 26);
      total++;
      if (sreq !== e_sreq) begin
        bad++;
        $display("FAIL basic c=%0d sleep_req got %b exp %b", c, sreq, e_sreq);
      end
      total++;
      if (aslp !== e_aslp) begin
        bad++;
        $display("FAIL basic c=%0d asleep got %b exp %b", c, aslp, e_aslp);
      end
      total++;
      if (wup !== e_wup) begin
        bad++;
        $display("FAIL basic c=%0d wakeup_req got %b exp %b", c, wup, e_wup);
      end
      step();
    end
  endtask

  task automatic test_pending_wake();
    logic [1:0] e_pend;
    logic       e_wup;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      i_irq_en   = 2'b01;
      i_irq      = (c == 5) ? 2'b01 : 2'b00;
      i_wfi      = (c == 10);
      i_cnt_done = (c == 10);
      i_pend_clr = (c == 15) ? 2'b01 : 2'b00;
      e_pend = ((c >= 6) && (c <= 15)) ? 2'b01 : 2'b00;
      e_wup  = (c == 11);
      total++;
      if (sreq !== 1'b0) begin
        bad++;
        $display("FAIL pending c=%0d sleep_req got %b exp 0", c, sreq);
      end
      total++;
      if (wup !== e_wup) begin
        bad++;
        $display("FAIL pending c=%0d wakeup_req got %b exp %b", c, wup, e_wup);
      end
      total++;
      if (pend !== e_pend) begin
        bad++;
        $display("FAIL pending c=%0d pending got %b exp %b", c, pend, e_pend);
      end
      step();
    end
  endtask

  task automatic test_masked_source();
    logic e_sreq, e_aslp, e_wup, e_p1;
    do_reset();
    for (int c = 0; c <= 18; c++) begin
      i_irq_en    = (c >= 9) ? 2'b11 : 2'b01;
      i_wfi       = (c == 2);
      i_cnt_done  = (c == 2);
      i_sleep_ack = (c == 3);
      i_irq       = (c == 6) ? 2'b10 : 2'b00;
      e_sreq = (c >= 3) && (c <= 9);
      e_aslp = (c >= 4) && (c <= 9);
      e_wup  = (c == 15);
      e_p1   = (c >= 7);
      total++;
      if (sreq !== e_sreq) begin
        bad++;
        $display("FAIL masked c=%0d sleep_req got %b exp %b", c, sreq, e_sreq);
      end
      total++;
      if (aslp !== e_aslp) begin
        bad++;
        $display("FAIL masked c=%0d asleep got %b exp %b", c, aslp, e_aslp);
      end
      total++;
      if (wup !== e_wup) begin
        bad++;
        $display("FAIL masked c=%0d wakeup_req got %b exp %b", c, wup, e_wup);
      end
      total++;
      if (pend[1] !== e_p1) begin
        bad++;
        $display("FAIL masked c=%0d pending1 got %b exp %b", c, pend[1], e_p1);
      end
      step();
    end
  endtask

  task automatic test_req_abort();
    logic [1:0] e_pend;
    logic       e_sreq, e_wup;
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      i_irq_en    = 2'b01;
      i_wfi       = (c == 2);
      i_cnt_done  = (c == 2);
      i_sleep_ack = (c == 3);
      i_irq       = (c == 3) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
      i_pend_clr  = (c == 6) ? 2'b10 : (c == 8) ? 2'b11 : 2'b00;
      e_sreq = (c == 3);
      e_wup  = (c == 4);
      e_pend = (c < 4) ? 2'b00 : (c <= 6) ? 2'b01 : (c <= 8) ? 2'b11 : 2'b00;
      total++;
      if (sreq !== e_sreq) begin
        bad++;
        $display("FAIL abort c=%0d sleep_req got %b exp %b", c, sreq, e_sreq);
      end
      total++;
      if (aslp !== 1'b0) begin
        bad++;
        $display("FAIL abort c=%0d asleep got %b exp 0", c, aslp);
      end
      total++;
      if (wup !== e_wup) begin
        bad++;
        $display("FAIL abort c=%0d wakeup_req got %b exp %b", c, wup, e_wup);
      end
      total++;
      if (pend !== e_pend) begin
        bad++;
        $display("FAIL abort c=%0d pending got %b exp %b", c, pend, e_pend);
      end
      step();
    end
  endtask

  // dut0 (no delay) pulses at K+2; dut (delay 4) is reset mid-WAKE and must never pulse.
  task automatic test_dly0_and_reset_in_wake();
    logic [1:0] e_pend;
    logic       e_sreq, e_aslp, e_wup0;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      i_irq_en    = 2'b01;
      i_wfi       = (c == 2);
      i_cnt_done  = (c == 2);
      i_sleep_ack = (c == 3);
      i_irq       = (c == 6) ? 2'b01 : 2'b00;
      i_rst_n     = (c != 8);
      e_sreq = (c >= 3) && (c <= 6);
      e_aslp = (c >= 4) && (c <= 6);
      e_wup0 = (c == 8);
      e_pend = ((c >= 7) && (c <= 8)) ? 2'b01 : 2'b00;
      total++;
      if (wup0 !== e_wup0) begin
        bad++;
        $display("FAIL dly0 c=%0d wakeup_req got %b exp %b", c, wup0, e_wup0);
      end
      total++;
      if (sreq0 !== e_sreq) begin
        bad++;
        $display("FAIL dly0 c=%0d sleep_req got %b exp %b", c, sreq0, e_sreq);
      end
      total++;
      if ({sreq, aslp} !== {e_sreq, e_aslp}) begin
        bad++;
        $display("FAIL rstwake c=%0d sleep_req/asleep got %b exp %b", c, {sreq, aslp}, {e_sreq, e_aslp});
      end
      total++;
      if (wup !== 1'b0) begin
        bad++;
        $display("FAIL rstwake c=%0d wakeup_req got %b exp 0", c, wup);
      end
      total++;
      if (pend !== e_pend) begin
        bad++;
        $display("FAIL rstwake c=%0d pending got %b exp %b", c, pend, e_pend);
      end
      step();
    end
    i_rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    i_rst_n = 1'b0;
    test_reset();
    test_basic_sleep();
    test_pending_wake();
    test_masked_source();
    test_req_abort();
    test_dly0_and_reset_in_wake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_sleep_ctrl.md
# serv_sleep_ctrl

Parametrised sleep/wake controller for the SERV core. It turns a decoded WFI into a sleep request with an acknowledge handshake, and latches per-source pending wake events under an enable mask. On wake it inserts a programmable restart delay before signalling the core to resume. It sits between the core's decode/state logic, the interrupt sources and the clock-gating/power logic.

## Interface
Parameters:
- IRQ_W, 2, number of wake/interrupt sources (1..32)
- WAKE_DLY, 4, restart delay in cycles between leaving SLEEP and the wakeup pulse (0..255)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_irq  in  IRQ_W  level-sensitive interrupt/wake sources
- i_irq_en  in  IRQ_W  per-source wake enable mask
- i_pend_clr  in  IRQ_W  per-source pending clear, one-cycle strobe
- i_wfi  in  1  WFI instruction being executed
- i_cnt_done  in  1  last cycle of the current serial instruction
- i_sleep_ack  in  1  gating logic confirms the core is halted
- o_sleep_req  out  1  request to halt/gate the core
- o_asleep  out  1  high while in SLEEP
- o_wakeup_req  out  1  one-cycle pulse: resume execution
- o_pending  out  IRQ_W  latched pending sources

## Operation
- Pending, per bit i, every cycle:
  - set when i_irq[i]=1;
  - else cleared when i_pend_clr[i]=1;
  - set wins over clear in the same cycle.
  - Pending is latched regardless of i_irq_en.
- wake = |((i_irq | o_pending) & i_irq_en), combinational, using the registered o_pending.
- States: RUN, REQ, SLEEP, WAKE. An 8-bit down-counter is used in WAKE.
- RUN:
  - i_wfi & i_cnt_done & wake -> stay RUN, pulse o_wakeup_req (WFI behaves as a NOP).
  - i_wfi & i_cnt_done & !wake -> REQ.
- REQ (o_sleep_req=1):
  - wake -> RUN, pulse o_wakeup_req. Wake takes priority over a simultaneous i_sleep_ack.
  - else i_sleep_ack -> SLEEP.
- SLEEP (o_sleep_req=1, o_asleep=1):
  - wake -> WAKE, counter loaded with WAKE_DLY.
- WAKE (o_sleep_req=0):
  - counter != 0 -> decrement.
  - counter == 0 -> RUN, pulse o_wakeup_req.
  - Further wake events in WAKE have no effect.
- i_wfi is ignored outside RUN. i_sleep_ack is ignored outside REQ.
- Pending bits are never cleared by the FSM; software clears them via i_pend_clr.

## Timing
- All outputs are registered.
- Reset values: state RUN, counter 0, o_sleep_req=0, o_asleep=0, o_wakeup_req=0, o_pending=0.
- Reset asserted mid-sleep or mid-WAKE returns to RUN on the next edge with no wakeup pulse.
- WFI qualified at cycle N -> o_sleep_req=1 at N+1.
- Ack at cycle M in REQ -> o_asleep=1 at M+1.
- Wake at cycle K in SLEEP:
  - o_sleep_req=0 and o_asleep=0 at K+1;
  - o_wakeup_req=1 at exactly K+2+WAKE_DLY, for one cycle;
  - state is RUN from that cycle on.
- Wake at cycle N in RUN (with WFI) or in REQ -> o_wakeup_req=1 at N+1, o_sleep_req=0 at N+1.
- i_irq pulse at cycle N -> o_pending bit set at N+1. A pending bit set this way counts as wake from N+1 onward, even after i_irq drops.
- o_sleep_req stays high from REQ entry until WAKE/RUN entry, with no glitches.

## Test plan
- Basic sleep, IRQ_W=2, WAKE_DLY=4: WFI at cycle 10, ack at 13, i_irq[1]=1 with en=2'b10 at 20 -> o_sleep_req high 11..20, o_asleep high 14..20, o_wakeup_req pulse at 26 only.
- Pending wake before WFI: i_irq[0] pulse at 5 with en=2'b01, WFI at 10 -> no o_sleep_req, o_wakeup_req at 11, o_pending=2'b01 until i_pend_clr[0] at 15 (0 at 16).
- Masked source: en=2'b01, i_irq[1] asserted during SLEEP -> stays SLEEP, o_pending[1]=1. Set en=2'b11 at cycle T -> WAKE at T+1.
- REQ abort and priority: i_sleep_ack and i_irq[0] (enabled) both in the first REQ cycle -> RUN next cycle with wakeup pulse, never o_asleep. Also: set and clear of the same pending bit in one cycle -> bit reads 1.
- WAKE_DLY=0: wake at K in SLEEP -> wakeup pulse at K+2. Reset (i_rst_n=0) asserted in WAKE -> all outputs 0 next cycle, no pulse after release.
